// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - time-multiplexes one shared S-box bank across the eight 6-bit groups of a round value
// Issues eight lookups on a registered bank port and assembles the 32-bit result nibble by nibble.
module sbox_sched #(
   parameter int LUT_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:48] din,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:32] dout,
   output logic [2:0]  lut_sel,
   output logic [1:6]  lut_in,
   input  logic [1:4]  lut_out,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LOOK, DONE} state_e;

   state_e      state_q;
   logic [1:48] hold_q;
   logic [2:0]  iss_q;
   logic [2:0]  cap_q;
   logic        iss_done_q;
   logic        pres_q;
   logic [1:32] dout_q;
   logic        out_valid_q;
   logic [2:0]  sel_q;
   logic [1:6]  lin_q;

   logic        cap_en;
   logic [5:0]  hold_base;
   logic [5:0]  dout_base;

   assign hold_base = ({3'b000, iss_q} * 6'd6) + 6'd1;
   assign dout_base = {1'b0, cap_q, 2'b00} + 6'd1;

   // pres_q marks a cycle in which a fresh lookup sits on the bank port;
   // a registered bank delivers its result one cycle later still.
   generate
      if (LUT_LAT == 1) begin : g_reg_bank
         logic pres2_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) pres2_q <= 1'b0;
            else     pres2_q <= pres_q;
         end
         assign cap_en = pres2_q;
      end else begin : g_comb_bank
         assign cap_en = pres_q;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         iss_q       <= '0;
         cap_q       <= '0;
         iss_done_q  <= 1'b0;
         pres_q      <= 1'b0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
         sel_q       <= '0;
         lin_q       <= '0;
      end else begin
         pres_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Index 0 is issued straight from din so the first lookup lands the cycle after accept.
                  hold_q     <= din;
                  sel_q      <= 3'd0;
                  lin_q      <= din[1:6];
                  pres_q     <= 1'b1;
                  iss_q      <= 3'd1;
                  cap_q      <= 3'd0;
                  iss_done_q <= 1'b0;
                  state_q    <= LOOK;
               end
            end
            LOOK: begin
               if (!iss_done_q) begin
                  sel_q  <= iss_q;
                  lin_q  <= hold_q[hold_base +: 6];
                  pres_q <= 1'b1;
                  iss_q  <= iss_q + 3'd1;
                  if (iss_q == 3'd7) iss_done_q <= 1'b1;
               end
               if (cap_en) begin
                  dout_q[dout_base +: 4] <= lut_out;
                  cap_q <= cap_q + 3'd1;
                  if (cap_q == 3'd7) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign lut_sel   = sel_q;
   assign lut_in    = lin_q;

endmodule

// File: tb/tb_sbox_sched.sv
// tb/tb_sbox_sched.sv - directed bench for sbox_sched with combinational and registered bank instances
// Both instances share the upstream/downstream stimulus; each has its own bank model.
module tb_sbox_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:48] din;
   logic        out_ready;
   logic        use_real;

   logic        in_ready0, out_valid0, busy0;
   logic [1:32] dout0;
   logic [2:0]  sel0;
   logic [1:6]  lin0;
   logic [1:4]  lout0;

   logic        in_ready1, out_valid1, busy1;
   logic [1:32] dout1;
   logic [2:0]  sel1;
   logic [1:6]  lin1;
   logic [1:4]  lout1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [1:4] stub(input logic [2:0] s, input logic [1:6] x);
      return {1'b0, s} ^ x[3:6];
   endfunction

   function automatic logic [1:4] s1(input logic [1:6] x);
      logic [63:0] row;
      logic [63:0] t;
      logic [3:0]  col;
      case ({x[1], x[6]})
         2'd0:    row = 64'hE4D12FB83A6C5907;
         2'd1:    row = 64'h0F74E2D1A6CB9538;
         2'd2:    row = 64'h41E8D62BFC973A50;
         default: row = 64'hFC8249175B3EA06D;
      endcase
      col = x[2:5];
      t = row >> {~col, 2'b00};
      return t[3:0];
   endfunction

   function automatic logic [1:32] model(input logic [1:48] d);
      logic [1:32] r;
      logic [1:6]  g;
      for (int k = 0; k < 8; k++) begin
         g = d[6*k+1 +: 6];
         r[4*k+1 +: 4] = stub(3'(k), g);
      end
      return r;
   endfunction

   assign lout0 = (use_real && sel0 == 3'd0) ? s1(lin0) : stub(sel0, lin0);

   always_ff @(posedge clk) lout1 <= stub(sel1, lin1);

   sbox_sched #(.LUT_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .din(din),
      .out_valid(out_valid0), .out_ready(out_ready), .dout(dout0),
      .lut_sel(sel0), .lut_in(lin0), .lut_out(lout0), .busy(busy0)
   );

   sbox_sched #(.LUT_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .din(din),
      .out_valid(out_valid1), .out_ready(out_ready), .dout(dout1),
      .lut_sel(sel1), .lut_in(lin1), .lut_out(lout1), .busy(busy1)
   );

   task automatic accept(input logic [1:48] d);
      in_valid = 1'b1;
      din      = d;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      out_ready = 1'b1;
      @(negedge clk);
      while ((busy0 || busy1) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy0 || busy1) begin
         errors++;
         $display("FAIL wait_idle: busy0=%0b busy1=%0b, required both 0", busy0, busy1);
      end
   endtask

   task automatic wait_valid0();
      int n = 0;
      @(negedge clk);
      while (!out_valid0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!out_valid0) begin
         errors++;
         $display("FAIL wait_valid0: out_valid0=0 after timeout, required 1");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b0; use_real = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid0, in_ready0, busy0, dout0, sel0, lin0} !== {1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 6'd0}) begin
         errors++;
         $display("FAIL reset0: ov=%0b ir=%0b busy=%0b dout=%h sel=%0d lin=%0d", out_valid0, in_ready0, busy0, dout0, sel0, lin0);
      end
      checks++;
      if ({out_valid1, in_ready1, busy1, dout1, sel1, lin1} !== {1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 6'd0}) begin
         errors++;
         $display("FAIL reset1: ov=%0b ir=%0b busy=%0b dout=%h sel=%0d lin=%0d", out_valid1, in_ready1, busy1, dout1, sel1, lin1);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stub_timing();
      use_real = 1'b0; out_ready = 1'b0;
      accept(48'h0);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c <= 8) begin
            checks++;
            if (sel0 !== 3'(c-1) || out_valid0 !== 1'b0) begin
               errors++;
               $display("FAIL comb_seq c=%0d: sel=%0d ov=%0b, required sel=%0d ov=0", c, sel0, out_valid0, c-1);
            end
            checks++;
            if (sel1 !== 3'(c-1) || out_valid1 !== 1'b0) begin
               errors++;
               $display("FAIL reg_seq c=%0d: sel=%0d ov=%0b, required sel=%0d ov=0", c, sel1, out_valid1, c-1);
            end
         end else begin
            checks++;
            if (out_valid0 !== 1'b1 || sel0 !== 3'd7) begin
               errors++;
               $display("FAIL comb_valid c=%0d: ov=%0b sel=%0d, required ov=1 sel=7", c, out_valid0, sel0);
            end
            checks++;
            if (out_valid1 !== (c == 10) || sel1 !== 3'd7) begin
               errors++;
               $display("FAIL reg_valid c=%0d: ov=%0b sel=%0d, required ov=%0b sel=7", c, out_valid1, sel1, c == 10);
            end
         end
      end
      checks++;
      if (dout0 !== 32'h01234567) begin
         errors++;
         $display("FAIL comb_dout: dout=%h, required 01234567", dout0);
      end
      checks++;
      if (dout1 !== 32'h01234567) begin
         errors++;
         $display("FAIL reg_dout: dout=%h, required 01234567", dout1);
      end
      wait_idle();
   endtask

   task automatic test_real_sbox();
      logic [5:0] vals [3] = '{6'd0, 6'd63, 6'd32};
      logic [3:0] exp_n [3] = '{4'hE, 4'hD, 4'h4};
      use_real = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         accept({vals[i], 42'h0});
         wait_valid0();
         checks++;
         if (dout0[1:4] !== exp_n[i]) begin
            errors++;
            $display("FAIL sbox1 in=%0d: nibble=%h, required %h", vals[i], dout0[1:4], exp_n[i]);
         end
         wait_idle();
         out_ready = 1'b0;
      end
      use_real = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [1:48] a = 48'h123456789ABC;
      logic [1:48] b = 48'hFEDCBA987654;
      out_ready = 1'b0;
      accept(a);
      wait_valid0();
      for (int c = 0; c < 20; c++) begin
         in_valid = c[0];
         din      = b;
         @(negedge clk);
         checks++;
         if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || dout0 !== model(a)) begin
            errors++;
            $display("FAIL hold c=%0d: ov=%0b ir=%0b dout=%h, required ov=1 ir=0 dout=%h", c, out_valid0, in_ready0, dout0, model(a));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL release: ov=%0b ir=%0b, required ov=0 ir=1", out_valid0, in_ready0);
      end
      wait_idle();
      accept(b);
      wait_valid0();
      checks++;
      if (dout0 !== model(b)) begin
         errors++;
         $display("FAIL next_block: dout=%h, required %h", dout0, model(b));
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      logic [1:48] c_d = 48'hA5A5A5A5A5A5;
      logic [1:48] d_d = 48'h0F1E2D3C4B5A;
      logic        seen = 1'b0;
      out_ready = 1'b1;
      accept(c_d);
      repeat (4) @(negedge clk);
      checks++;
      if (sel0 !== 3'd3) begin
         errors++;
         $display("FAIL mid_sel: sel=%0d, required 3", sel0);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid0, in_ready0, busy0, dout0, sel0, lin0} !== {1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 6'd0}) begin
         errors++;
         $display("FAIL async_reset: ov=%0b ir=%0b busy=%0b dout=%h sel=%0d lin=%0d", out_valid0, in_ready0, busy0, dout0, sel0, lin0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid0 || out_valid1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL aborted_valid: out_valid seen=1, required 0");
      end
      accept(d_d);
      wait_valid0();
      checks++;
      if (dout0 !== model(d_d)) begin
         errors++;
         $display("FAIL after_reset: dout=%h, required %h", dout0, model(d_d));
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic [1:48] blk [4] = '{48'h111111111111, 48'hC3C3C3C3C3C3, 48'h6DB6DB6DB6DB, 48'h0};
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      din       = blk[0];
      for (int b = 0; b < 3; b++) begin
         n = 0;
         while (!in_ready0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (!in_ready0) begin
            errors++;
            $display("FAIL b2b_ready b=%0d: in_ready=0 after timeout, required 1", b);
         end
         for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 8) begin
               checks++;
               if (sel0 !== 3'(c-1) || in_ready0 !== 1'b0 || out_valid0 !== 1'b0) begin
                  errors++;
                  $display("FAIL b2b_look b=%0d c=%0d: sel=%0d ir=%0b ov=%0b, required sel=%0d ir=0 ov=0", b, c, sel0, in_ready0, out_valid0, c-1);
               end
            end else if (c == 9) begin
               checks++;
               if (out_valid0 !== 1'b1 || sel0 !== 3'd7 || dout0 !== model(blk[b])) begin
                  errors++;
                  $display("FAIL b2b_done b=%0d: ov=%0b sel=%0d dout=%h, required ov=1 sel=7 dout=%h", b, out_valid0, sel0, dout0, model(blk[b]));
               end
               din = blk[b+1];
            end else begin
               checks++;
               if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || sel0 !== 3'd7) begin
                  errors++;
                  $display("FAIL b2b_idle b=%0d: ir=%0b ov=%0b sel=%0d, required ir=1 ov=0 sel=7", b, in_ready0, out_valid0, sel0);
               end
               if (b == 2) in_valid = 1'b0;
            end
         end
      end
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_stub_timing();
      test_real_sbox();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sbox_sched.md
Name: sbox_sched

Overview:
- Sequencer that time-multiplexes one shared S-box lookup bank (the S1..S8 tables behind a select mux) across the eight 6-bit groups of a 48-bit round value.
- Produces the 32-bit substitution result over 8 lookup cycles, so one bank serves the whole round function instead of eight parallel tables.
- Sits between the key-mix XOR stage and the P-permutation of the DES round datapath.
- Upstream and downstream connect through valid/ready handshakes.

Parameters:
- LUT_LAT, 0: bank read latency in cycles.
  - 0 = combinational: lut_out is valid in the same cycle as lut_sel/lut_in.
  - 1 = registered: lut_out is valid the cycle after. Other values are illegal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  din is valid.
- in_ready  output  1  block can accept din.
- din  input  [1:48]  expanded, key-mixed round value. Bits 1..6 feed box 1, 7..12 box 2, …, 43..48 box 8.
- out_valid  output  1  dout holds a completed result.
- out_ready  input  1  downstream accepts dout.
- dout  output  [1:32]  substitution result. Bits 1..4 = box 1 output, …, 29..32 = box 8 output.
- lut_sel  output  3  bank select: 0 = S1 … 7 = S8.
- lut_in  output  [1:6]  6-bit lookup index to the bank.
- lut_out  input  [1:4]  bank result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst high) forces all state as follows:
  - state = IDLE, issue index = 0, capture index = 0.
  - dout = 0, out_valid = 0, in_ready = 1 after reset release, busy = 0.
  - lut_sel = 0, lut_in = 0.
  - Reset mid-lookup discards the operation; no partial result is ever flagged valid.
- States: IDLE, LOOK, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch din into a 48-bit holding register, clear issue and capture indices, go to LOOK.
- LOOK:
  - in_ready = 0.
  - Each cycle while issue index i <= 7, drive lut_sel = i and lut_in = held bits [6i+1 : 6i+6], then increment i.
  - lut_sel/lut_in are registered outputs, so the lookup for index i appears on the bank port one cycle after the decision.
  - Capture: when the result for index k is valid (1 cycle after issue when LUT_LAT=0, 2 cycles when LUT_LAT=1), write lut_out into dout bits [4k+1 : 4k+4], then increment k.
  - After k = 7 is written, go to DONE.
  - dout bits not yet written hold their previous value. dout is not cleared at accept.
- DONE:
  - out_valid = 1; dout is stable.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - out_ready high while out_valid is low has no effect.
- Timing, from accept at cycle T:
  - LUT_LAT=0: lookups presented T+1..T+8, out_valid rises at T+9.
  - LUT_LAT=1: lookups presented T+1..T+8, out_valid rises at T+10.
  - Throughput: one block per 10 cycles (LUT_LAT=0) or 11 cycles (LUT_LAT=1), counting the DONE→IDLE return.
- No overlap: in_valid is ignored in LOOK and DONE. din changes outside the accept cycle have no effect.
- When not in LOOK, lut_sel and lut_in hold their last value. The bank is side-effect free, so this is harmless.
- Index counters are 3-bit. The terminal count is detected explicitly at 7; wrap-around past 7 must never issue a ninth lookup.

Test Plan:
1. Stub bank with lut_out = {1'b0, lut_sel}, LUT_LAT=0, din = 0 → exactly 8 lookups with lut_sel 0..7 in order; dout = 32'h01234567; out_valid rises exactly 9 cycles after accept.
2. Real S-box bank, LUT_LAT=0, din bits 1..6 = 6'd0, 7..48 = 0 → dout[1:4] = 4'hE. Then din bits 1..6 = 6'd63 → dout[1:4] = 4'hD. Then din bits 1..6 = 6'd32 → dout[1:4] = 4'h4.
3. Stub bank registered (LUT_LAT=1), same stimulus as test 1 → dout = 32'h01234567; out_valid rises 10 cycles after accept; no nibble misaligned.
4. Backpressure: hold out_ready = 0 for 20 cycles in DONE and pulse in_valid with new din → dout and out_valid stay stable, in_ready = 0, new din not accepted. Raise out_ready → return to IDLE, then accept the next block.
5. Assert rst at the 4th lookup cycle → all outputs return to reset values immediately (asynchronously); out_valid is never asserted for the aborted block. The next block after release completes correctly.
6. Back-to-back: in_valid held high and out_ready held high for 3 blocks → each block accepted only in IDLE; dout matches the reference model per block; no lookup count other than 8 per block.
